wb_arb2_timeout: RTL and testbench

WB_ARB2_TIMEOUT -- requirements
Module: wb_arb2_timeout

---
 rtl/wb_arb2_timeout.sv | 145 ++++++++++++++
 tb/tb_wb_arb2_timeout.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb2_timeout.sv
// ============================================================================
// Module   : wb_arb2_timeout
// Purpose  : Two-master Wishbone arbiter with round-robin grant and watchdog abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_arb2_timeout #(
   parameter int DATABITS     = 16,
   parameter int TIMEOUT_BITS = 8,
   parameter int TIMEOUT      = 200
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [1:0]            m_cyc_i,
   input  logic [1:0]            m_stb_i,
   input  logic [1:0]            m_we_i,
   input  logic [63:0]           m_adr_i,
   input  logic [2*DATABITS-1:0] m_dat_i,
   output logic [1:0]            m_ack_o,
   output logic [1:0]            m_err_o,
   output logic [1:0]            m_stall_o,
   output logic [DATABITS-1:0]   m_dat_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [31:0]           s_adr_o,
   output logic [DATABITS-1:0]   s_dat_o,
   input  logic                  s_ack_i,
   input  logic                  s_err_i,
   input  logic                  s_stall_i,
   input  logic [DATABITS-1:0]   s_dat_i,
   output logic [1:0]            grant_o,
   output logic                  timeout_o
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_bus0  = 2'd1;
   localparam logic [1:0] c_st_bus1  = 2'd2;
   localparam logic [1:0] c_st_abort = 2'd3;

   localparam logic [TIMEOUT_BITS-1:0] c_timeout = TIMEOUT_BITS'(TIMEOUT);
   localparam logic [TIMEOUT_BITS-1:0] c_one     = TIMEOUT_BITS'(1);

   logic [1:0]              r_state;
   logic [1:0]              w_next;
   logic                    r_owner;
   logic                    r_last_grant;
   logic [TIMEOUT_BITS-1:0] r_cnt;
   logic                    r_tmo;
   logic                    w_bus;
   logic                    w_owner_cyc;

   assign w_bus       = (r_state == c_st_bus0) || (r_state == c_st_bus1);
   assign w_owner_cyc = m_cyc_i[r_owner];

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_st_idle: begin
            case (m_cyc_i)
               2'b01:   w_next = c_st_bus0;
               2'b10:   w_next = c_st_bus1;
               2'b11:   w_next = r_last_grant ? c_st_bus0 : c_st_bus1;
               default: w_next = c_st_idle;
            endcase
         end
         c_st_bus0, c_st_bus1: begin
            // Release beats the watchdog; a slave response in the final cycle beats the abort.
            if (!w_owner_cyc)
               w_next = c_st_idle;
            else if ((r_cnt == c_timeout) && !s_ack_i && !s_err_i)
               w_next = c_st_abort;
         end
         default: begin
            if (!w_owner_cyc)
               w_next = c_st_idle;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state      <= c_st_idle;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_tmo        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_tmo   <= w_bus && (w_next == c_st_abort);
         case (r_state)
            c_st_idle: begin
               r_cnt <= '0;
               if (w_next == c_st_bus0)
                  r_owner <= 1'b0;
               else if (w_next == c_st_bus1)
                  r_owner <= 1'b1;
            end
            c_st_bus0, c_st_bus1: begin
               if (!w_owner_cyc)
                  r_last_grant <= r_owner;
               if (s_ack_i || s_err_i)
                  r_cnt <= '0;
               else if (r_cnt != c_timeout)
                  r_cnt <= r_cnt + c_one;
            end
            default: begin
               if (!w_owner_cyc)
                  r_last_grant <= r_owner;
            end
         endcase
      end
   end

   always_comb begin
      s_cyc_o   = 1'b0;
      s_stb_o   = 1'b0;
      s_we_o    = 1'b0;
      s_adr_o   = r_owner ? m_adr_i[63:32] : m_adr_i[31:0];
      s_dat_o   = r_owner ? m_dat_i[2*DATABITS-1:DATABITS] : m_dat_i[DATABITS-1:0];
      m_ack_o   = 2'b00;
      m_err_o   = 2'b00;
      m_stall_o = 2'b11;
      if (w_bus) begin
         s_cyc_o            = w_owner_cyc;
         s_stb_o            = m_stb_i[r_owner];
         s_we_o             = m_we_i[r_owner];
         // Responses are dropped once the owner has let go of cyc.
         m_ack_o[r_owner]   = s_ack_i & w_owner_cyc;
         m_err_o[r_owner]   = s_err_i & w_owner_cyc;
         m_stall_o[r_owner] = s_stall_i;
      end else if (r_state == c_st_abort) begin
         m_err_o[r_owner]   = r_tmo;
      end
   end

   assign m_dat_o   = s_dat_i;
   assign timeout_o = r_tmo;
   assign grant_o   = (r_state == c_st_bus0) ? 2'b01 :
                      (r_state == c_st_bus1) ? 2'b10 : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_wb_arb2_timeout.sv
// ============================================================================
// Module   : tb_wb_arb2_timeout
// Purpose  : Directed self-checking bench for wb_arb2_timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wb_arb2_timeout;

   localparam int DATABITS     = 16;
   localparam int TIMEOUT_BITS = 8;
   localparam int TIMEOUT      = 12;

   logic                  clk_i = 1'b0;
   logic                  reset_i;
   logic [1:0]            m_cyc_i, m_stb_i, m_we_i;
   logic [63:0]           m_adr_i;
   logic [2*DATABITS-1:0] m_dat_i;
   logic [1:0]            m_ack_o, m_err_o, m_stall_o;
   logic [DATABITS-1:0]   m_dat_o;
   logic                  s_cyc_o, s_stb_o, s_we_o;
   logic [31:0]           s_adr_o;
   logic [DATABITS-1:0]   s_dat_o;
   logic                  s_ack_i, s_err_i, s_stall_i;
   logic [DATABITS-1:0]   s_dat_i;
   logic [1:0]            grant_o;
   logic                  timeout_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   wb_arb2_timeout #(
      .DATABITS(DATABITS), .TIMEOUT_BITS(TIMEOUT_BITS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
      .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o), .m_dat_o(m_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic release_all;
      m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00; s_ack_i = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset;
      reset_i = 1'b1;
      m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
      m_adr_i = {32'h0000_5678, 32'h0000_1234};
      m_dat_i = {16'hB1B1, 16'hA0A0};
      s_ack_i = 1'b0; s_err_i = 1'b0; s_stall_i = 1'b0; s_dat_i = '0;
      tick();
      tick();
      checks++;
      if ({grant_o, timeout_o, s_cyc_o, s_stb_o} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=00000", {grant_o, timeout_o, s_cyc_o, s_stb_o});
      end
      checks++;
      if ({m_ack_o, m_err_o, m_stall_o} !== 6'b0000_11) begin
         errors++;
         $display("FAIL reset_resp got=%b exp=000011", {m_ack_o, m_err_o, m_stall_o});
      end
      #2 reset_i = 1'b0;
      tick();
   endtask

   task automatic test_single;
      m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
      #1;
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL single_pregrant got=%b exp=00", grant_o);
      end
      tick();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL single_grant got=%b exp=01", grant_o);
      end
      checks++;
      if ({s_cyc_o, s_stb_o, s_adr_o, m_stall_o} !== {1'b1, 1'b1, 32'h0000_1234, 2'b10}) begin
         errors++;
         $display("FAIL single_fwd got cyc=%b stb=%b adr=%h stall=%b exp 1 1 00001234 10",
                  s_cyc_o, s_stb_o, s_adr_o, m_stall_o);
      end
      s_ack_i = 1'b1; s_dat_i = 16'hBEEF;
      #1;
      checks++;
      if (m_ack_o !== 2'b01 || m_dat_o !== 16'hBEEF) begin
         errors++; $display("FAIL single_ack got ack=%b dat=%h exp ack=01 dat=beef", m_ack_o, m_dat_o);
      end
      release_all();
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL single_release got=%b exp=00", grant_o);
      end
   endtask

   task automatic test_contention;
      #2 reset_i = 1'b1;
      #2 reset_i = 1'b0;
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL cont_first got=%b exp=01", grant_o);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (m_stall_o[1] !== 1'b1 || s_adr_o !== 32'h0000_1234) begin
            errors++; $display("FAIL cont_stall1 got stall=%b adr=%h exp stall[1]=1 adr=00001234", m_stall_o, s_adr_o);
         end
         tick();
      end
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      tick();
      checks++;
      if (grant_o !== 2'b00) begin
         errors++; $display("FAIL cont_idle got=%b exp=00", grant_o);
      end
      tick();
      checks++;
      if (grant_o !== 2'b10 || s_adr_o !== 32'h0000_5678) begin
         errors++; $display("FAIL cont_second got grant=%b adr=%h exp 10 00005678", grant_o, s_adr_o);
      end
      release_all();
   endtask

   task automatic test_fairness;
      logic [1:0] exp_seq [4];
      exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
      m_cyc_i = 2'b11; m_stb_i = 2'b11;
      tick();
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (grant_o !== exp_seq[r]) begin
            errors++; $display("FAIL fair_grant round=%0d got=%b exp=%b", r, grant_o, exp_seq[r]);
         end
         s_ack_i = 1'b1;
         for (int k = 0; k < 3; k++) tick();
         s_ack_i = 1'b0;
         m_cyc_i = ~exp_seq[r]; m_stb_i = ~exp_seq[r];
         tick();
         checks++;
         if (grant_o !== 2'b00) begin
            errors++; $display("FAIL fair_idle round=%0d got=%b exp=00", r, grant_o);
         end
         m_cyc_i = 2'b11; m_stb_i = 2'b11;
         tick();
      end
      release_all();
   endtask

   task automatic test_timeout;
      m_cyc_i = 2'b10; m_stb_i = 2'b10;
      tick();
      checks++;
      if (grant_o !== 2'b10) begin
         errors++; $display("FAIL tmo_grant got=%b exp=10", grant_o);
      end
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick();
         checks++;
         if (m_err_o !== 2'b00 || timeout_o !== 1'b0 || s_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early cycle=%0d got err=%b tmo=%b cyc=%b exp 00 0 1", i, m_err_o, timeout_o, s_cyc_o);
         end
      end
      tick();
      checks++;
      if ({m_err_o, timeout_o, s_cyc_o, grant_o} !== 6'b10_1_0_00) begin
         errors++;
         $display("FAIL tmo_fire got err=%b tmo=%b cyc=%b grant=%b exp 10 1 0 00", m_err_o, timeout_o, s_cyc_o, grant_o);
      end
      tick();
      checks++;
      if ({m_err_o, timeout_o, s_cyc_o} !== 4'b00_0_0) begin
         errors++; $display("FAIL tmo_pulse got err=%b tmo=%b cyc=%b exp 00 0 0", m_err_o, timeout_o, s_cyc_o);
      end
      m_cyc_i = 2'b00; m_stb_i = 2'b00;
      tick();
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL tmo_after got=%b exp=01", grant_o);
      end
      release_all();
   endtask

   task automatic test_race;
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick();
      for (int i = 1; i <= TIMEOUT; i++) tick();
      s_ack_i = 1'b1;
      #1;
      checks++;
      if (m_ack_o !== 2'b01) begin
         errors++; $display("FAIL race_ack got=%b exp=01", m_ack_o);
      end
      tick();
      s_ack_i = 1'b0;
      checks++;
      if ({m_err_o, timeout_o, grant_o} !== 5'b00_0_01) begin
         errors++; $display("FAIL race_noabort got err=%b tmo=%b grant=%b exp 00 0 01", m_err_o, timeout_o, grant_o);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (grant_o !== 2'b01 || timeout_o !== 1'b0) begin
         errors++; $display("FAIL race_cleared got grant=%b tmo=%b exp 01 0", grant_o, timeout_o);
      end
      release_all();
   endtask

   task automatic test_late_ack;
      m_cyc_i = 2'b01; m_stb_i = 2'b01;
      tick();
      m_cyc_i = 2'b00; m_stb_i = 2'b00; s_ack_i = 1'b1; s_err_i = 1'b1;
      #1;
      checks++;
      if (m_ack_o !== 2'b00 || m_err_o !== 2'b00) begin
         errors++; $display("FAIL late_drop got ack=%b err=%b exp 00 00", m_ack_o, m_err_o);
      end
      tick();
      checks++;
      if (m_ack_o !== 2'b00 || m_err_o !== 2'b00 || grant_o !== 2'b00) begin
         errors++; $display("FAIL late_idle got ack=%b err=%b grant=%b exp 00 00 00", m_ack_o, m_err_o, grant_o);
      end
      s_ack_i = 1'b0; s_err_i = 1'b0;
      tick();
   endtask

   task automatic test_midreset;
      m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
      tick();
      checks++;
      if (s_we_o !== 1'b1 || s_dat_o !== 16'hA0A0 || grant_o !== 2'b01) begin
         errors++; $display("FAIL mid_write got we=%b dat=%h grant=%b exp 1 a0a0 01", s_we_o, s_dat_o, grant_o);
      end
      m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
      #1 reset_i = 1'b1;
      #1;
      checks++;
      if ({s_cyc_o, grant_o, m_ack_o, m_err_o} !== 7'b0_00_00_00) begin
         errors++;
         $display("FAIL mid_async got cyc=%b grant=%b ack=%b err=%b exp 0 00 00 00", s_cyc_o, grant_o, m_ack_o, m_err_o);
      end
      #1 reset_i = 1'b0; s_ack_i = 1'b0;
      tick();
      checks++;
      if (grant_o !== 2'b01) begin
         errors++; $display("FAIL mid_regrant got=%b exp=01", grant_o);
      end
      release_all();
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_timeout();
      test_race();
      test_late_ack();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
